// File: rtl/ahb_master_arbiter.sv
// AHB bus arbiter for four masters. Round-robin selection at transfer
// boundaries, a per-owner hold limit, locked-sequence support and parking
// on a default master. All outputs come straight from flops.
module ahb_master_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 8
) (
  input  logic                   HCLK,
  input  logic                   HRST,
  input  logic [NUM_MASTERS-1:0] HBUSREQ_i,
  input  logic [NUM_MASTERS-1:0] HLOCK_i,
  input  logic [1:0]             HTRANS_i,
  input  logic                   HREADY_i,
  output logic [NUM_MASTERS-1:0] HGRANT_o,
  output logic [1:0]             HMASTER_o,
  output logic [1:0]             HMASTER_D_o,
  output logic                   HMASTLOCK_o
);

  localparam logic [1:0] DEF_M    = 2'(DEFAULT_MASTER);
  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  typedef enum logic [1:0] {PARK, OWN, LOCK} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               master_q, master_d, master_dq;
  logic [NUM_MASTERS-1:0]   grant_q;
  logic                     mastlock_q;
  logic [3:0]               hold_q;

  logic                     boundary, xfer;
  logic [NUM_MASTERS-1:0]   others;
  logic [2:0]               pick_all, pick_oth;

  // First set bit of m searching upward from base with wrap; {found, idx}.
  function automatic logic [2:0] rr_pick(input logic [NUM_MASTERS-1:0] m,
                                         input logic [1:0] base);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = base + 2'(i);
      if (!r[2] && m[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign boundary = HREADY_i && (HTRANS_i == T_IDLE || HTRANS_i == T_NONSEQ);
  assign xfer     = HREADY_i && (HTRANS_i == T_NONSEQ || HTRANS_i == T_SEQ);
  assign others   = HBUSREQ_i & ~(NUM_MASTERS'(1) << master_q);
  assign pick_all = rr_pick(HBUSREQ_i, master_q + 2'd1);
  assign pick_oth = rr_pick(others, master_q + 2'd1);

  // Next owner/state; only boundary cycles can move the grant.
  always_comb begin
    state_d  = state_q;
    master_d = master_q;
    if (boundary) begin
      case (state_q)
        PARK: begin
          if (pick_all[2]) begin
            master_d = pick_all[1:0];
            state_d  = HLOCK_i[pick_all[1:0]] ? LOCK : OWN;
          end
        end
        default: begin
          // A locked owner keeps the bus until it drops HLOCK at a boundary.
          if (!(state_q == LOCK && HLOCK_i[master_q])) begin
            if (HBUSREQ_i[master_q] && (hold_q < HOLD_MAX || !pick_oth[2])) begin
              master_d = master_q;
              state_d  = HLOCK_i[master_q] ? LOCK : OWN;
            end else if (pick_oth[2]) begin
              master_d = pick_oth[1:0];
              state_d  = HLOCK_i[pick_oth[1:0]] ? LOCK : OWN;
            end else begin
              master_d = DEF_M;
              state_d  = PARK;
            end
          end
        end
      endcase
    end
  end

  // Grant, owner and lock registers move together.
  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) begin
      state_q    <= PARK;
      master_q   <= DEF_M;
      grant_q    <= NUM_MASTERS'(1) << DEF_M;
      mastlock_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      master_q   <= master_d;
      grant_q    <= NUM_MASTERS'(1) << master_d;
      mastlock_q <= (state_d == LOCK);
    end
  end

  // Data-phase owner follows the address-phase owner when the bus advances.
  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST)          master_dq <= DEF_M;
    else if (HREADY_i) master_dq <= master_q;
  end

  // Saturating hold counter; restarts whenever a new tenure begins.
  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST)
      hold_q <= 4'd0;
    else if (master_d != master_q || state_q == PARK)
      hold_q <= 4'd0;
    else if (xfer && hold_q < HOLD_MAX)
      hold_q <= hold_q + 4'd1;
  end

  assign HGRANT_o    = grant_q;
  assign HMASTER_o   = master_q;
  assign HMASTER_D_o = master_dq;
  assign HMASTLOCK_o = mastlock_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter with hand-computed expectations.
module tb_ahb_master_arbiter;

  logic       HCLK = 1'b0;
  logic       HRST;
  logic [3:0] HBUSREQ_i, HLOCK_i;
  logic [1:0] HTRANS_i;
  logic       HREADY_i;
  logic [3:0] HGRANT_o;
  logic [1:0] HMASTER_o, HMASTER_D_o;
  logic       HMASTLOCK_o;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;

  ahb_master_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0), .MAX_HOLD(8)) dut (
    .HCLK(HCLK), .HRST(HRST), .HBUSREQ_i(HBUSREQ_i), .HLOCK_i(HLOCK_i),
    .HTRANS_i(HTRANS_i), .HREADY_i(HREADY_i), .HGRANT_o(HGRANT_o),
    .HMASTER_o(HMASTER_o), .HMASTER_D_o(HMASTER_D_o), .HMASTLOCK_o(HMASTLOCK_o)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; sample 1 ns after it.
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] lck,
                       input logic [1:0] tr, input logic rdy);
    HBUSREQ_i = req; HLOCK_i = lck; HTRANS_i = tr; HREADY_i = rdy;
  endtask

  task automatic do_reset();
    drive(4'b0000, 4'b0000, IDLE, 1'b1);
    HRST = 1'b1;
    step(); step();
    HRST = 1'b0;
  endtask

  logic [3:0] prev_g;
  logic [1:0] exp_rot [4];
  logic       moved;

  initial begin
    exp_rot[0] = 2'd1; exp_rot[1] = 2'd2; exp_rot[2] = 2'd3; exp_rot[3] = 2'd0;
    drive(4'b0000, 4'b0000, IDLE, 1'b1);
    HRST = 1'b1;
    #3;
    chk("rst_grant", HGRANT_o, 4'b0001);
    chk("rst_master", HMASTER_o, 0);
    chk("rst_master_d", HMASTER_D_o, 0);
    chk("rst_lock", HMASTLOCK_o, 0);
    step();
    HRST = 1'b0;

    // Idle bus, single request from master 2.
    drive(4'b0100, 4'b0000, IDLE, 1'b1);
    step();
    chk("idle_grant", HGRANT_o, 4'b0100);
    chk("idle_master", HMASTER_o, 2);
    chk("idle_state", dut.state_q, 1);
    chk("idle_lock", HMASTLOCK_o, 0);

    // Round-robin rotation with holds saturating at 8 transfers.
    do_reset();
    drive(4'b0001, 4'b0000, IDLE, 1'b1);
    step();
    chk("rr_start", HMASTER_o, 0);
    drive(4'b1111, 4'b0000, NONSEQ, 1'b1);
    for (int k = 0; k < 4; k++) begin
      prev_g = HGRANT_o;
      repeat (8) step();
      chk("rr_hold", HGRANT_o, prev_g);
      step();
      chk("rr_rot", HMASTER_o, exp_rot[k]);
      chk("rr_onehot", HGRANT_o, 4'b0001 << exp_rot[k]);
    end

    // Wait states during a SEQ burst freeze grant and data-phase owner.
    do_reset();
    drive(4'b0010, 4'b0000, IDLE, 1'b1);
    step(); step();
    chk("ws_grant0", HGRANT_o, 4'b0010);
    chk("ws_md0", HMASTER_D_o, 1);
    drive(4'b1010, 4'b0000, SEQ, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ws_grant", HGRANT_o, 4'b0010);
      chk("ws_md", HMASTER_D_o, 1);
    end
    drive(4'b1010, 4'b0000, SEQ, 1'b1);
    step();
    chk("seq_nobound", HGRANT_o, 4'b0010);

    // Locked sequence from master 2 with everyone else requesting.
    do_reset();
    drive(4'b0100, 4'b0100, IDLE, 1'b1);
    step();
    chk("lk_grant", HGRANT_o, 4'b0100);
    chk("lk_lock", HMASTLOCK_o, 1);
    drive(4'b1111, 4'b0100, NONSEQ, 1'b1);
    moved = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (HGRANT_o !== 4'b0100 || HMASTLOCK_o !== 1'b1) moved = 1'b1;
    end
    chk("lk_stable", moved, 0);
    drive(4'b1111, 4'b0000, NONSEQ, 1'b1);
    step();
    chk("lk_rel_grant", HGRANT_o, 4'b1000);
    chk("lk_rel_master", HMASTER_o, 3);
    chk("lk_rel_lock", HMASTLOCK_o, 0);

    // All requests drop: park on master 0.
    drive(4'b0000, 4'b0000, IDLE, 1'b1);
    step();
    chk("park_grant", HGRANT_o, 4'b0001);
    chk("park_master", HMASTER_o, 0);
    chk("park_state", dut.state_q, 0);
    chk("park_lock", HMASTLOCK_o, 0);

    // Asynchronous reset in the middle of a burst owned by master 3.
    do_reset();
    drive(4'b1000, 4'b0000, IDLE, 1'b1);
    step();
    drive(4'b1000, 4'b0000, NONSEQ, 1'b1);
    step();
    drive(4'b1000, 4'b0000, SEQ, 1'b1);
    step();
    chk("ar_pre_md", HMASTER_D_o, 3);
    #2 HRST = 1'b1;
    #1;
    chk("ar_grant", HGRANT_o, 4'b0001);
    chk("ar_master", HMASTER_o, 0);
    chk("ar_md", HMASTER_D_o, 0);
    chk("ar_lock", HMASTLOCK_o, 0);
    step();
    HRST = 1'b0;
    step();
    chk("ar_nobound", HGRANT_o, 4'b0001);
    drive(4'b1000, 4'b0000, IDLE, 1'b1);
    step();
    chk("ar_first_arb", HGRANT_o, 4'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
